// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port RAM access sequencer between a CPU request port
// and a stallable word RAM. Every access is followed by one idle GAP cycle.
// Optional feature: define MEM_RMW_EN to turn partial-byte stores into a
// read-modify-write (read phase + write phase); otherwise every store is a
// full-word write and cpu_be is ignored.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_stall
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, ERR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // stall cycles in the current phase
  logic            ld_q, ld_d;       // transaction is a load
  logic            wr_q, wr_d;       // current phase drives mem_we
  logic            rmw_q, rmw_d;     // a write phase follows this read phase
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            in_range;
  logic            acc_wr, acc_rmw, acc_skip;

  assign in_range = (cpu_addr >> ADDR_WIDTH) == 32'd0;

`ifdef MEM_RMW_EN
  logic [3:0] be_q, be_d;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction

  // Partial stores read first; an empty byte mask needs no RAM access at all.
  assign acc_wr   = cpu_we && (cpu_be == 4'hF);
  assign acc_rmw  = cpu_we && (cpu_be != 4'hF) && (cpu_be != 4'h0);
  assign acc_skip = cpu_we && (cpu_be == 4'h0);
`else
  logic unused_be;
  assign unused_be = ^cpu_be;
  assign acc_wr    = cpu_we;
  assign acc_rmw   = 1'b0;
  assign acc_skip  = 1'b0;
`endif

  // State and latched-request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      wr_q    <= 1'b0;
      rmw_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef MEM_RMW_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      wr_q    <= wr_d;
      rmw_q   <= rmw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
`ifdef MEM_RMW_EN
      be_q    <= be_d;
`endif
    end
  end

  // Next-state: accept in IDLE, wait out stalls in ACCESS, one GAP per phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    wr_d    = wr_q;
    rmw_d   = rmw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
`ifdef MEM_RMW_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (!in_range) begin
            state_d = ERR;
          end else begin
            ld_d    = !cpu_we;
            wr_d    = acc_wr;
            rmw_d   = acc_rmw;
            addr_d  = cpu_addr;
            data_d  = cpu_wdata;
            cnt_d   = '0;
`ifdef MEM_RMW_EN
            be_d    = cpu_be;
`endif
            state_d = acc_skip ? GAP : ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!mem_stall) begin
          state_d = GAP;
          if (ld_q) rdata_d = mem_din;
`ifdef MEM_RMW_EN
          if (rmw_q) data_d = merge(mem_din, data_q, be_q);
`endif
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (rmw_q) begin
          // read phase done: issue the merged write as a fresh access
          state_d = ACCESS;
          wr_d    = 1'b1;
          rmw_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_ready = (state_q == IDLE);
  assign cpu_done  = (state_q == ERR) || ((state_q == GAP) && !rmw_q);
  assign cpu_err   = (state_q == ERR);
  assign cpu_rdata = rdata_q;
  assign mem_cs    = (state_q == ACCESS);
  assign mem_we    = mem_cs && wr_q;
  assign mem_addr  = addr_q;
  assign mem_dout  = mem_we ? data_q : 32'd0;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, word-address width of the attached data RAM; addresses with cpu_addr[31:ADDR_WIDTH] != 0 are out of range.
REQ-002 Parameter TIMEOUT, default 32, maximum cycles mem_cs is held high in one access before abort.
REQ-003 Ports (name  direction  width  meaning); one clock; reset is asynchronous and active-low:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-low reset
 cpu_req  in  1  access request, qualified by cpu_ready
 cpu_we  in  1  1=store, 0=load
 cpu_be  in  4  byte enables for store (bit i -> cpu_wdata[8i+7:8i])
 cpu_addr  in  32  word address
 cpu_wdata  in  32  store data
 cpu_ready  out  1  controller idle, request accepted this cycle
 cpu_done  out  1  one-cycle completion pulse
 cpu_err  out  1  one-cycle error pulse (range or timeout), coincident with cpu_done
 cpu_rdata  out  32  load data, held until next completion
 mem_cs  out  1  RAM chip select
 mem_we  out  1  RAM write enable
 mem_addr  out  32  RAM address
 mem_dout  out  32  RAM write data
 mem_din  in  32  RAM read data
 mem_stall  in  1  RAM busy; access completes on rising edge with mem_cs=1 and mem_stall=0

Function
REQ-004 States: IDLE, ACCESS, GAP, ERR; cpu_ready=1 only in IDLE.
REQ-005 IDLE, cpu_req=1, address in range -> latch cpu_we/cpu_be/cpu_addr/cpu_wdata, go ACCESS; mem_cs=1 from next cycle.
REQ-006 IDLE, cpu_req=1, address out of range -> go ERR, no mem_cs assertion; ERR pulses cpu_done=1, cpu_err=1 for one cycle, then IDLE.
REQ-007 ACCESS: mem_cs=1, mem_addr/mem_we/mem_dout driven from latched values, stable for whole access.
REQ-008 ACCESS completes on rising edge with mem_stall=0; load captures mem_din into cpu_rdata at that edge.
REQ-009 After completion go GAP: mem_cs=0, mem_we=0 for exactly one cycle so the RAM's access counter clears; no back-to-back cs.
REQ-010 GAP of final phase pulses cpu_done=1 (cpu_err=0), then IDLE; earliest next acceptance is the cycle after cpu_done.
REQ-011 Timeout counter clears on ACCESS entry, increments each ACCESS cycle with mem_stall=1; reaching TIMEOUT -> drop mem_cs, go ERR; cpu_rdata unchanged.
REQ-012 A 7-stall RAM gives load latency: accept edge + 8 ACCESS cycles + 1 GAP; cpu_done in the 10th cycle after acceptance.
REQ-013 cpu_req outside IDLE is ignored (no queueing); inputs sampled only at acceptance.
REQ-014 mem_dout=0 whenever mem_we=0.

Reset
REQ-015 rst low asynchronously forces IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_dout=0, cpu_rdata=0, cpu_done=0, cpu_err=0, counter=0; cpu_ready=1 after release.
REQ-016 Reset mid-access abandons it with no completion pulse; mem_cs falls with rst.

Configuration
REQ-017 Macro MEM_RMW_EN defined: store with cpu_be != 4'b1111 performs read phase (ACCESS, GAP), merges enabled bytes of cpu_wdata into read word, then write phase (ACCESS, GAP); cpu_done only after write GAP; timeout in either phase -> ERR, no write issued after read timeout; cpu_be=0 completes without memory access.
REQ-018 Macro MEM_RMW_EN undefined: cpu_be ignored, every store is one full-word write phase.

Verification
REQ-019 Load addr 0x3, RAM word 0x3 = 0xDEADBEEF, 7 stall cycles -> mem_cs high 8 cycles, cpu_rdata=0xDEADBEEF, cpu_done pulse, cpu_err=0.
REQ-020 Store addr 0x5 data 0x12345678 be=4'hF -> mem_we=1 with mem_dout=0x12345678 for whole access, one GAP cycle, later load returns 0x12345678.
REQ-021 Request addr 0x20 (ADDR_WIDTH=5) -> no mem_cs, cpu_done=1 and cpu_err=1 same cycle, 2 cycles after acceptance.
REQ-022 mem_stall tied 1, TIMEOUT=32 -> mem_cs drops after 32 cycles, cpu_err pulse, cpu_rdata keeps previous value.
REQ-023 MEM_RMW_EN, word 0xAABBCCDD, store be=4'b0010 data 0x00001100 -> read phase then write 0xAABB11DD, single cpu_done.
REQ-024 rst low during ACCESS -> mem_cs=0 immediately, no cpu_done, new request accepted the cycle after rst release.
